// File: rtl/pedal_sensor_cond.sv
// Pedal cadence conditioning: synchronizer, glitch filter, windowed rise counter
// and once-per-revolution torque smoothing for desiredDrive.
module pedal_sensor_cond #(
    parameter int FILT_CYC = 8,
    parameter int WIN_CYC  = 65536,
    parameter int NP_MIN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence_raw,
    input  logic [11:0] torque,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling
);

    localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          cad_filt;
    logic [FW-1:0] filt_cnt;
    logic          cad_rise;
    logic [WW-1:0] win_cnt;
    logic [4:0]    rise_cnt;
    logic [15:0]   accum;
    logic [4:0]    cadence_new;

    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic inc);
        if (inc && (v != 5'd31)) begin
            return v + 5'd1;
        end
        return v;
    endfunction

    // Leaky average; accum <= 65520 keeps the 16-bit result from wrapping.
    function automatic logic [15:0] accum_next(input logic [15:0] a, input logic [11:0] t);
        return a - (a >> 4) + {4'b0000, t};
    endfunction

    // Synchronizer and glitch filter; cad_rise fires on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cad_filt <= 1'b0;
            filt_cnt <= '0;
            cad_rise <= 1'b0;
        end else begin
            sync1    <= cadence_raw;
            sync2    <= sync1;
            cad_rise <= 1'b0;
            if (sync2 == cad_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                cad_filt <= sync2;
                filt_cnt <= '0;
                cad_rise <= sync2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign cadence_new = sat_inc(rise_cnt, cad_rise);

    // Window counter; cadence and not_pedaling are latched only at window end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            rise_cnt     <= '0;
            cadence      <= '0;
            not_pedaling <= 1'b1;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt      <= '0;
            rise_cnt     <= '0;
            cadence      <= cadence_new;
            not_pedaling <= (int'(cadence_new) < NP_MIN);
        end else begin
            win_cnt  <= win_cnt + WW'(1);
            rise_cnt <= cadence_new;
        end
    end

    // Torque accumulator; a stopped pedal reseeds instead of averaging.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accum <= '0;
        end else if (cad_rise) begin
            if (not_pedaling) begin
                accum <= {torque, 4'b0000};
            end else begin
                accum <= accum_next(accum, torque);
            end
        end
    end

    assign avg_torque = accum[15:4];

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Bench for pedal_sensor_cond: two instances (256- and 1024-clock windows)
// checked every cycle against an event-level model plus literal expectations.
module tb_pedal_sensor_cond;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cadence_raw = 1'b0;
    logic [11:0] torque = 12'd0;
    logic [11:0] avg0, avg1;
    logic [4:0]  cad0, cad1;
    logic        np0, np1;

    pedal_sensor_cond #(.FILT_CYC(8), .WIN_CYC(256), .NP_MIN(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .cadence_raw(cadence_raw), .torque(torque),
        .avg_torque(avg0), .cadence(cad0), .not_pedaling(np0)
    );

    pedal_sensor_cond #(.FILT_CYC(8), .WIN_CYC(1024), .NP_MIN(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .cadence_raw(cadence_raw), .torque(torque),
        .avg_torque(avg1), .cadence(cad1), .not_pedaling(np1)
    );

    always #5 clk = ~clk;

    localparam int FILT = 8;
    int win_len[2] = '{256, 1024};

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: raw samples are seen two edges late; a level is accepted
    // once FILT consecutive synchronized samples all disagree with the current one.
    logic hist[$];
    logic m_filt;
    logic m_rise;
    logic rise_now;
    bit   run;
    int   m_k;
    int   m_cnt[2];
    int   m_cad[2];
    logic m_np[2];
    int   m_acc[2];

    always @(posedge clk) begin
        if (!rst_n) begin
            hist = {};
            for (int j = 0; j < FILT + 2; j++) hist.push_front(1'b0);
            m_filt = 1'b0;
            m_rise = 1'b0;
            m_k = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0;
                m_cad[i] = 0;
                m_np[i]  = 1'b1;
                m_acc[i] = 0;
            end
        end else begin
            rise_now = m_rise;
            m_k++;
            for (int i = 0; i < 2; i++) begin
                if (rise_now)
                    m_acc[i] = m_np[i] ? int'(torque) * 16 : m_acc[i] - m_acc[i] / 16 + int'(torque);
                if (m_k % win_len[i] == 0) begin
                    m_cad[i] = m_cnt[i] + (rise_now ? 1 : 0);
                    if (m_cad[i] > 31) m_cad[i] = 31;
                    m_np[i]  = (m_cad[i] < 2);
                    m_cnt[i] = 0;
                end else if (rise_now && m_cnt[i] < 31) begin
                    m_cnt[i]++;
                end
            end
            run = 1'b1;
            for (int j = 1; j <= FILT; j++) if (hist[j] == m_filt) run = 1'b0;
            m_rise = 1'b0;
            if (run) begin
                m_filt = ~m_filt;
                m_rise = m_filt;
            end
            hist.push_front(cadence_raw);
            void'(hist.pop_back());
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cadence0", int'(cad0), m_cad[0]);
            check("not_ped0", int'(np0), int'(m_np[0]));
            check("avg0", int'(avg0), m_acc[0] / 16);
            check("cadence1", int'(cad1), m_cad[1]);
            check("not_ped1", int'(np1), int'(m_np[1]));
            check("avg1", int'(avg1), m_acc[1] / 16);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_k(input int modv, input int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((m_k % modv != target) && guard < 4096);
        if (m_k % modv != target) begin
            n_chk++;
            n_bad++;
            $display("FAIL wait_k: window phase %0d never reached (now %0d)", target, m_k % modv);
        end
    endtask

    task automatic pedal(input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            cadence_raw = 1'b1;
            step(hi);
            cadence_raw = 1'b0;
            step(lo);
        end
    endtask

    initial begin
        // reset held over three edges with the raw input toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_en = 1'b1;
            cadence_raw = ~cadence_raw;
        end
        check("rst_cad0", int'(cad0), 0);
        check("rst_np0", int'(np0), 1);
        check("rst_avg0", int'(avg0), 0);
        check("rst_cad1", int'(cad1), 0);
        cadence_raw = 1'b0;
        rst_n = 1'b1;

        // 5-cycle glitches every 40 cycles for over three windows
        pedal(5, 35, 20);
        check("glitch_cad0", int'(cad0), 0);
        check("glitch_np0", int'(np0), 1);
        check("glitch_avg0", int'(avg0), 0);

        // one rise while not pedaling seeds the average
        torque = 12'h800;
        pedal(20, 20, 1);
        check("seed_avg0", int'(avg0), 'h800);
        check("seed_avg1", int'(avg1), 'h800);

        // steady 32/32 pedaling over five aligned windows
        wait_k(256, 0);
        pedal(32, 32, 20);
        check("steady_cad0", int'(cad0), 4);
        check("steady_np0", int'(np0), 0);
        check("steady_avg0", int'(avg0), 'h800);

        // one rise with torque 0 while pedaling: 0x8000 - 0x800 = 0x7800
        torque = 12'd0;
        pedal(20, 20, 1);
        check("avg_step0", int'(avg0), 'h780);

        // fastest pedaling with full-scale torque: saturation and accumulator bound
        torque = 12'hFFF;
        pedal(8, 8, 192);
        check("sat_cad1", int'(cad1), 31);
        check("sat_np1", int'(np1), 0);
        check("sat_cad0", int'(cad0), 16);

        // second rise lands on the window-end edge
        wait_k(256, 0);
        wait_k(256, 20);
        pedal(20, 1, 1);
        wait_k(256, 245);
        cadence_raw = 1'b1;
        step(20);
        cadence_raw = 1'b0;
        check("edge_cad0", int'(cad0), 2);
        check("edge_np0", int'(np0), 0);
        wait_k(256, 0);
        check("after_edge_cad0", int'(cad0), 0);
        check("after_edge_np0", int'(np0), 1);

        // reset in the middle of pedaling
        pedal(8, 8, 25);
        rst_n = 1'b0;
        step(1);
        check("midrst_cad0", int'(cad0), 0);
        check("midrst_np0", int'(np0), 1);
        check("midrst_avg0", int'(avg0), 0);
        check("midrst_avg1", int'(avg1), 0);
        step(2);
        rst_n = 1'b1;
        pedal(8, 8, 40);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
